// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and defaults for the UART word transmitter
package uart_pkg;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    localparam int UART_CLKS_PER_BIT = 234;
    localparam int UART_FRAME_BITS = 10;
endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1 byte serialiser with valid/ready input and a done pulse
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       done,
    output logic       tx
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    tx_state_e state;
    logic [BW-1:0] baud;
    logic [2:0] bit_idx;
    logic [7:0] sh;
    logic last;
    assign last = baud == BW'(CLKS_PER_BIT - 1);
    assign done = state == TX_STOP && last;
    // the final stop cycle also accepts, so consecutive bytes have no gap
    assign ready = state == TX_IDLE || done;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= TX_IDLE;
            baud <= '0;
            bit_idx <= '0;
            sh <= '0;
            tx <= 1'b1;
        end else if (ready && valid) begin
            state <= TX_START;
            baud <= '0;
            bit_idx <= '0;
            sh <= data;
            tx <= 1'b0;
        end else if (state != TX_IDLE) begin
            baud <= last ? '0 : baud + 1'b1;
            if (last) begin
                case (state)
                    TX_START: begin
                        state <= TX_DATA;
                        bit_idx <= '0;
                        tx <= sh[0];
                    end
                    TX_DATA: begin
                        state <= bit_idx == 3'd7 ? TX_STOP : TX_DATA;
                        bit_idx <= bit_idx + 3'd1;
                        sh <= {1'b0, sh[7:1]};
                        tx <= bit_idx == 3'd7 ? 1'b1 : sh[1];
                    end
                    default: state <= TX_IDLE;
                endcase
            end
        end
    end
endmodule

// File: rtl/uart_word_tx.sv
// uart_word_tx: accepts 32-bit words and sends NUM_BYTES of each LSB-first over 8N1 UART
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int NUM_BYTES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] word_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        tx_o,
    output logic        busy_o
);
    if (CLKS_PER_BIT < 2 || NUM_BYTES < 1 || NUM_BYTES > 4) begin : g_bad_param
        $error("uart_word_tx: CLKS_PER_BIT must be >= 2 and NUM_BYTES in 1..4");
    end
    logic busy;
    logic [31:0] word;
    logic [1:0] byte_idx;
    logic byte_ready, byte_done, byte_valid, last_byte, hs;
    logic [7:0] byte_data;
    assign last_byte = byte_idx == 2'(NUM_BYTES - 1);
    assign hs = valid_i && ready_o && byte_ready;
    // while busy, the next byte is offered so it starts on the stop bit's last edge
    assign byte_valid = busy ? !last_byte : valid_i;
    assign byte_data = busy ? word[15:8] : word_i[7:0];
    assign ready_o = !busy;
    assign busy_o = busy;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            word <= '0;
            byte_idx <= '0;
        end else if (hs) begin
            busy <= 1'b1;
            word <= word_i;
            byte_idx <= '0;
        end else if (busy && byte_done) begin
            busy <= !last_byte;
            word <= word >> 8;
            byte_idx <= last_byte ? 2'd0 : byte_idx + 2'd1;
        end
    end
    uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
        .clk(clk),
        .rst_n(rst_n),
        .data(byte_data),
        .valid(byte_valid),
        .ready(byte_ready),
        .done(byte_done),
        .tx(tx_o)
    );
endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: scenario bench with a host-side UART decoder and waveform model
module tb_uart_word_tx;
    localparam int C = 4;
    localparam int NB = 4;
    logic clk, rst_n, valid_i, ready_o, tx_o, busy_o;
    logic [31:0] word_i;
    int checks = 0;
    int errors = 0;
    int frame_err = 0;
    logic [7:0] rx_q[$];

    uart_word_tx #(.CLKS_PER_BIT(C), .NUM_BYTES(NB)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .word_i(word_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .tx_o(tx_o),
        .busy_o(busy_o)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // host-side receiver: sample each bit in its middle, on falling clock edges
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx_o === 1'b0) begin
                repeat (C + C / 2) @(negedge clk);
                b[0] = tx_o;
                for (int j = 1; j < 8; j++) begin
                    repeat (C) @(negedge clk);
                    b[j] = tx_o;
                end
                repeat (C) @(negedge clk);
                if (tx_o !== 1'b1) frame_err++;
                rx_q.push_back(b);
            end
        end
    end

    function automatic logic exp_level(input logic [31:0] w, input int t);
        int fr = t / (10 * C);
        int bp = (t % (10 * C)) / C;
        logic [7:0] by = 8'(w >> (8 * fr));
        return bp == 0 ? 1'b0 : bp == 9 ? 1'b1 : by[bp-1];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ready_o !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        wait_ready();
        word_i = w;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        int k = 0;
        while (rx_q.size() < n && k < 3000) begin
            tick();
            k++;
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        valid_i = 0;
        word_i = 0;
        rst_n = 1;
        #2 rst_n = 0;
        repeat (3) tick();
        checks++;
        if (tx_o !== 1'b1 || ready_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold tx=%b ready=%b busy=%b want 1 1 0", tx_o, ready_o, busy_o);
        end
        rst_n = 1;
        tick();
        checks++;
        if (tx_o !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx_o); end
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready_o); end
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
        repeat (20) begin
            tick();
            if (tx_o !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL reset_idle low_cycles=%0d want 0", bad); end
    endtask

    task automatic test_single_word();
        logic [31:0] w = 32'h0000_00A5;
        int base = rx_q.size();
        send_word(w);
        for (int t = 0; t < 10 * NB * C; t++) begin
            checks++;
            if ({tx_o, ready_o} !== {exp_level(w, t), 1'b0}) begin
                errors++;
                $display("FAIL single_wave t=%0d tx,ready=%b%b want %b0", t, tx_o, ready_o, exp_level(w, t));
            end
            tick();
        end
        checks++;
        if (ready_o !== 1'b1 || tx_o !== 1'b1) begin
            errors++;
            $display("FAIL single_ready_rise ready=%b tx=%b want 1 1", ready_o, tx_o);
        end
        wait_rx(base + NB);
        for (int i = 0; i < NB; i++) begin
            checks++;
            if (rx_q.size() <= base + i || rx_q[base+i] !== 8'(w >> (8 * i))) begin
                errors++;
                $display("FAIL single_byte%0d got %h want %h", i, rx_q.size() > base + i ? rx_q[base+i] : 8'hxx, 8'(w >> (8 * i)));
            end
        end
    endtask

    task automatic test_busy_reject();
        logic [31:0] w = 32'h1122_3344;
        int base = rx_q.size();
        send_word(w);
        repeat (19) tick();
        word_i = 32'hFFFF_FFFF;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        wait_ready();
        repeat (60) tick();
        checks++;
        if (rx_q.size() - base != NB) begin
            errors++;
            $display("FAIL busy_count got %0d want %0d", rx_q.size() - base, NB);
        end
        for (int i = 0; i < NB; i++) begin
            checks++;
            if (rx_q.size() <= base + i || rx_q[base+i] !== 8'(w >> (8 * i))) begin
                errors++;
                $display("FAIL busy_byte%0d got %h want %h", i, rx_q.size() > base + i ? rx_q[base+i] : 8'hxx, 8'(w >> (8 * i)));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] ws = {32'h1234_5678, 32'hDEAD_BEEF};
        int base = rx_q.size();
        int n = 0;
        wait_ready();
        word_i = ws[31:0];
        valid_i = 1'b1;
        tick();
        word_i = ws[63:32];
        while (ready_o !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (n != 10 * NB * C || tx_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_rise cycles=%0d tx=%b want %0d 1", n, tx_o, 10 * NB * C);
        end
        tick();
        checks++;
        if (ready_o !== 1'b0 || tx_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_start ready=%b tx=%b want 0 0", ready_o, tx_o);
        end
        valid_i = 1'b0;
        wait_rx(base + 2 * NB);
        for (int i = 0; i < 2 * NB; i++) begin
            checks++;
            if (rx_q.size() <= base + i || rx_q[base+i] !== 8'(ws >> (8 * i))) begin
                errors++;
                $display("FAIL b2b_byte%0d got %h want %h", i, rx_q.size() > base + i ? rx_q[base+i] : 8'hxx, 8'(ws >> (8 * i)));
            end
        end
    endtask

    task automatic test_capture();
        logic [31:0] w = 32'hCAFE_F00D;
        int base = rx_q.size();
        send_word(w);
        word_i = 32'h0;
        wait_rx(base + NB);
        for (int i = 0; i < NB; i++) begin
            checks++;
            if (rx_q.size() <= base + i || rx_q[base+i] !== 8'(w >> (8 * i))) begin
                errors++;
                $display("FAIL capture_byte%0d got %h want %h", i, rx_q.size() > base + i ? rx_q[base+i] : 8'hxx, 8'(w >> (8 * i)));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w = $urandom & ~32'h0000_0800;
        logic [31:0] w2 = 32'h0000_0055;
        int base;
        send_word(w);
        repeat ((10 + 1 + 3) * C) tick();
        #1;
        checks++;
        if (tx_o !== 1'b0) begin errors++; $display("FAIL mid_pre_tx got %b want 0", tx_o); end
        rst_n = 0;
        #1;
        checks++;
        if (tx_o !== 1'b1 || ready_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_async tx=%b ready=%b busy=%b want 1 1 0", tx_o, ready_o, busy_o);
        end
        repeat (3) tick();
        rst_n = 1;
        repeat (60) tick();
        base = rx_q.size();
        send_word(w2);
        wait_rx(base + NB);
        for (int i = 0; i < NB; i++) begin
            checks++;
            if (rx_q.size() <= base + i || rx_q[base+i] !== 8'(w2 >> (8 * i))) begin
                errors++;
                $display("FAIL mid_after_byte%0d got %h want %h", i, rx_q.size() > base + i ? rx_q[base+i] : 8'hxx, 8'(w2 >> (8 * i)));
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        int base = rx_q.size();
        int fe = frame_err;
        for (int k = 0; k < 8; k++) begin
            logic [31:0] w = $urandom;
            repeat ($urandom_range(0, 5)) tick();
            send_word(w);
            for (int i = 0; i < NB; i++) exp_q.push_back(8'(w >> (8 * i)));
        end
        wait_rx(base + exp_q.size());
        repeat (60) tick();
        checks++;
        if (rx_q.size() - base != exp_q.size()) begin
            errors++;
            $display("FAIL rand_count got %0d want %0d", rx_q.size() - base, exp_q.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (rx_q.size() <= base + i || rx_q[base+i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_byte%0d got %h want %h", i, rx_q.size() > base + i ? rx_q[base+i] : 8'hxx, exp_q[i]);
            end
        end
        checks++;
        if (frame_err != fe) begin errors++; $display("FAIL rand_stop_bits errors=%0d want 0", frame_err - fe); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_busy_reject();
        test_back_to_back();
        test_capture();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
